xadc_drp_sequencer: RTL and testbench

- Controller that sequences the XADC dynamic reconfiguration port (DRP) after each end-of-conversion.
- Walks a fixed list of result-register addresses round-robin and returns each 12-bit result tagged with its channel index over a valid/ready stream.
- Sits between the XADC primitive and the consumers: seven-segment display path, logging or threshold logic.
- Detects DRP read timeouts and conversion overruns.

---
 rtl/xadc_drp_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_xadc_drp_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xadc_drp_sequencer.sv
// xadc_drp_sequencer: after each XADC end-of-conversion, reads the next result
// register over the DRP (round-robin over NUM_CH addresses starting at
// ADDR_BASE) and hands the 12-bit result plus channel index to a valid/ready
// consumer. Flags DRP read timeouts and dropped conversions as sticky errors.
// Optional build macro XADC_SEQ_AVG_EN: average four passes per channel and
// only emit the averaged result on every fourth pass.
module xadc_drp_sequencer #(
    parameter int         NUM_CH    = 4,
    parameter logic [6:0] ADDR_BASE = 7'h10,
    parameter int         TIMEOUT   = 63
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        eoc,
    output logic        den,
    output logic        dwe,
    output logic [6:0]  daddr,
    input  logic        drdy,
    input  logic [15:0] do_in,
    output logic [11:0] sample,
    output logic [1:0]  ch,
    output logic        valid,
    input  logic        ready,
    input  logic        clr,
    output logic        timeout_err,
    output logic        overrun,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;

    localparam logic [1:0] LAST_IDX   = 2'(NUM_CH - 1);
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [1:0]  idx;
    logic [1:0]  idx_next;
    logic        pending;
    logic [7:0]  timer;
    logic [11:0] result;
    logic        read_done;
    logic        read_timeout;
    logic        out_taken;
    logic        overrun_hit;
    logic        emit;
    logic        advance;
    logic        unused_low;

    assign result       = do_in[15:4];
    assign unused_low   = ^do_in[3:0];
    assign dwe          = 1'b0;
    assign busy         = (state != IDLE);
    assign idx_next     = (idx == LAST_IDX) ? 2'd0 : idx + 2'd1;
    assign read_done    = (state == WAIT) && drdy;
    assign read_timeout = (state == WAIT) && !drdy && (timer == TIMER_LAST);
    assign out_taken    = (state == OUT) && valid && ready;
    assign overrun_hit  = eoc && (state != IDLE) && pending;

`ifdef XADC_SEQ_AVG_EN
    logic [13:0] acc [0:3];
    logic [1:0]  pass;
    logic [13:0] acc_sum;

    assign acc_sum = acc[idx] + {2'b00, result};
    assign emit    = (pass == 2'd3);
`else
    assign emit    = 1'b1;
`endif

    // A read that produces no output advances the channel immediately; one that
    // produces output advances only once the consumer has taken it.
    assign advance = (read_done && !emit) || read_timeout || out_taken;

    // Main sequencer: issue one DRP read per conversion, wait for drdy or give
    // up after TIMEOUT cycles, then hold the result until it is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            den    <= 1'b0;
            daddr  <= ADDR_BASE;
            timer  <= 8'd0;
            sample <= 12'd0;
            ch     <= 2'd0;
            valid  <= 1'b0;
        end else begin
            den <= 1'b0;
            case (state)
                IDLE: begin
                    if (eoc || pending) begin
                        den   <= 1'b1;
                        daddr <= ADDR_BASE + {5'b00000, idx};
                        state <= REQ;
                    end
                end
                REQ: begin
                    timer <= 8'd0;
                    state <= WAIT;
                end
                WAIT: begin
                    timer <= timer + 8'd1;
                    if (drdy) begin
                        if (emit) begin
`ifdef XADC_SEQ_AVG_EN
                            sample <= acc_sum[13:2];
`else
                            sample <= result;
`endif
                            ch    <= idx;
                            valid <= 1'b1;
                            state <= OUT;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (timer == TIMER_LAST) begin
                        state <= IDLE;
                    end
                end
                OUT: begin
                    if (ready) begin
                        valid <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Channel pointer (and, when averaging, the pass counter that ticks on wrap).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= 2'd0;
`ifdef XADC_SEQ_AVG_EN
            pass <= 2'd0;
`endif
        end else if (advance) begin
            idx <= idx_next;
`ifdef XADC_SEQ_AVG_EN
            if (idx == LAST_IDX) begin
                pass <= pass + 2'd1;
            end
`endif
        end
    end

`ifdef XADC_SEQ_AVG_EN
    // Per-channel running sums; cleared once the fourth pass has consumed them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                acc[i] <= 14'd0;
            end
        end else if (read_done) begin
            acc[idx] <= emit ? 14'd0 : acc_sum;
        end else if (read_timeout && emit) begin
            acc[idx] <= 14'd0;
        end
    end
`endif

    // One-deep memory of a conversion that arrived while a read was in flight;
    // a conversion landing in the same cycle IDLE consumes it re-arms it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
        end else if (state == IDLE) begin
            pending <= pending & eoc;
        end else if (eoc) begin
            pending <= 1'b1;
        end
    end

    // Sticky error flags: a new error event wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (read_timeout) begin
                timeout_err <= 1'b1;
            end else if (clr) begin
                timeout_err <= 1'b0;
            end
            if (overrun_hit) begin
                overrun <= 1'b1;
            end else if (clr) begin
                overrun <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_xadc_drp_sequencer.sv
// tb_xadc_drp_sequencer: scoreboard bench for xadc_drp_sequencer. Stimulus
// pushes the expected DRP address and expected output into queues; a DRP
// responder and an output monitor pop and compare independently.
// Define XADC_SEQ_AVG_EN to exercise the averaging build (NUM_CH=1).
module tb_xadc_drp_sequencer;
`ifdef XADC_SEQ_AVG_EN
    localparam int NUM_CH = 1;
`else
    localparam int NUM_CH = 4;
`endif
    localparam logic [6:0] ADDR_BASE = 7'h10;
    localparam int         TIMEOUT   = 63;

    logic        clk = 1'b0;
    logic        rst;
    logic        eoc;
    logic        den;
    logic        dwe;
    logic [6:0]  daddr;
    logic        drdy;
    logic [15:0] do_in;
    logic [11:0] sample;
    logic [1:0]  ch;
    logic        valid;
    logic        ready;
    logic        clr;
    logic        timeout_err;
    logic        overrun;
    logic        busy;

    typedef struct {
        logic [15:0] data;
        int          delay;
        bit          respond;
    } stim_t;

    stim_t       stim_q[$];
    logic [6:0]  addr_q[$];
    logic [13:0] exp_q[$];
    stim_t       cur;

    int tests     = 0;
    int fails     = 0;
    int den_count = 0;
    int den0;
    bit ready_rand = 1'b0;

    int m_idx  = 0;
    int m_pass = 0;
    int m_sum[4] = '{0, 0, 0, 0};

    bit          held = 1'b0;
    logic [11:0] h_sample;
    logic [1:0]  h_ch;
    logic [13:0] exp_v;

    xadc_drp_sequencer #(
        .NUM_CH(NUM_CH),
        .ADDR_BASE(ADDR_BASE),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .eoc(eoc),
        .den(den),
        .dwe(dwe),
        .daddr(daddr),
        .drdy(drdy),
        .do_in(do_in),
        .sample(sample),
        .ch(ch),
        .valid(valid),
        .ready(ready),
        .clr(clr),
        .timeout_err(timeout_err),
        .overrun(overrun),
        .busy(busy)
    );

    // 100 MHz system clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model of one conversion: what the consumer should eventually see.
    task automatic model_read(input logic [11:0] res, input bit timed_out);
`ifdef XADC_SEQ_AVG_EN
        int contrib;
        contrib = timed_out ? 0 : int'(res);
        if (m_pass == 3) begin
            if (!timed_out) begin
                exp_q.push_back({2'(m_idx), 12'((m_sum[m_idx] + contrib) / 4)});
            end
            m_sum[m_idx] = 0;
        end else begin
            m_sum[m_idx] += contrib;
        end
        if (m_idx == NUM_CH - 1) begin
            m_pass = (m_pass + 1) % 4;
        end
`else
        if (!timed_out) begin
            exp_q.push_back({2'(m_idx), res});
        end
`endif
        m_idx = (m_idx + 1) % NUM_CH;
    endtask

    task automatic pulse_eoc();
        @(posedge clk); #1 eoc = 1'b1;
        @(posedge clk); #1 eoc = 1'b0;
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
    endtask

    // Queue one conversion: DRP response, expected address and expected result.
    task automatic applyStimulus(input logic [15:0] data, input int delay, input bit respond);
        stim_t s;
        s.data    = data;
        s.delay   = delay;
        s.respond = respond;
        stim_q.push_back(s);
        addr_q.push_back(ADDR_BASE + 7'(m_idx));
        model_read(data[15:4], !respond);
        pulse_eoc();
    endtask

    // Wait for two consecutive idle cycles so a pending re-read is not missed.
    task automatic wait_idle();
        int run;
        run = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (!busy) run++;
            else run = 0;
            if (run >= 2) return;
        end
        tests++;
        fails++;
        $display("[TB] FAIL wait_idle: busy still %0b after 1000 cycles", busy);
    endtask

    // Random backpressure when enabled.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (ready_rand) ready = 1'($urandom_range(0, 1));
        end
    end

    // DRP responder: checks each address against the expected one and answers
    // after the delay chosen by the stimulus.
    initial begin
        drdy  = 1'b0;
        do_in = 16'h0000;
        forever begin
            @(negedge clk);
            if (den && !rst) begin
                den_count++;
                if (addr_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_den: daddr %0h with no read queued", daddr);
                end else begin
                    checkOutput("daddr", 32'(daddr), 32'(addr_q.pop_front()));
                end
                if (stim_q.size() != 0) begin
                    cur = stim_q.pop_front();
                    if (cur.respond) begin
                        repeat (cur.delay) @(posedge clk);
                        #1 drdy = 1'b1; do_in = cur.data;
                        @(posedge clk);
                        #1 drdy = 1'b0; do_in = 16'h0000;
                    end
                end
            end
        end
    end

    // Output monitor: pops the scoreboard on every handshake and checks that a
    // stalled output stays stable.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 1'b0;
            end else begin
                if (valid && held) begin
                    checkOutput("hold_sample", 32'(sample), 32'(h_sample));
                    checkOutput("hold_ch", 32'(ch), 32'(h_ch));
                end
                if (valid && ready) begin
                    held = 1'b0;
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("[TB] FAIL unexpected_valid: sample %0h ch %0d with nothing expected", sample, ch);
                    end else begin
                        exp_v = exp_q.pop_front();
                        checkOutput("sample", 32'(sample), 32'(exp_v[11:0]));
                        checkOutput("ch", 32'(ch), 32'(exp_v[13:12]));
                    end
                end else if (valid) begin
                    held     = 1'b1;
                    h_sample = sample;
                    h_ch     = ch;
                end else begin
                    held = 1'b0;
                end
            end
        end
    end

    // Directed scenarios followed by a randomized run.
    initial begin
        rst   = 1'b1;
        eoc   = 1'b0;
        clr   = 1'b0;
        ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_den", 32'(den), 32'd0);
        checkOutput("rst_dwe", 32'(dwe), 32'd0);
        checkOutput("rst_daddr", 32'(daddr), 32'h10);
        checkOutput("rst_sample", 32'(sample), 32'd0);
        checkOutput("rst_ch", 32'(ch), 32'd0);
        checkOutput("rst_valid", 32'(valid), 32'd0);
        checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
        checkOutput("rst_overrun", 32'(overrun), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

`ifdef XADC_SEQ_AVG_EN
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(16'((i * 100) << 4), 3, 1'b1);
            wait_idle();
        end
        checkOutput("avg_single_output", 32'(exp_q.size()), 32'd0);
`else
        den0 = den_count;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(16'hABC0, 3, 1'b1);
            wait_idle();
        end
        checkOutput("den_per_eoc", 32'(den_count - den0), 32'd4);

        ready = 1'b0;
        applyStimulus(16'($urandom), 5, 1'b1);
        for (int c = 0; c < 100 && !valid; c++) @(negedge clk);
        repeat (20) begin
            @(negedge clk);
            checkOutput("bp_valid", 32'(valid), 32'd1);
        end
        @(posedge clk); #1 ready = 1'b1;
        wait_idle();

        applyStimulus(16'($urandom), 0, 1'b0);
        repeat (TIMEOUT + 1) @(negedge clk);
        checkOutput("timeout_not_early", 32'(timeout_err), 32'd0);
        @(negedge clk);
        checkOutput("timeout_err_set", 32'(timeout_err), 32'd1);
        checkOutput("timeout_idle", 32'(busy), 32'd0);
        pulse_clr();
        @(negedge clk);
        checkOutput("timeout_clr", 32'(timeout_err), 32'd0);
        applyStimulus(16'($urandom), TIMEOUT, 1'b1);
        wait_idle();
        checkOutput("drdy_beats_timeout", 32'(timeout_err), 32'd0);

        den0 = den_count;
        applyStimulus(16'($urandom), 20, 1'b1);
        repeat (5) @(posedge clk);
        applyStimulus(16'($urandom), 4, 1'b1);
        @(negedge clk);
        checkOutput("pending_no_overrun", 32'(overrun), 32'd0);
        pulse_eoc();
        @(negedge clk);
        checkOutput("overrun_set", 32'(overrun), 32'd1);
        wait_idle();
        checkOutput("overrun_reads", 32'(den_count - den0), 32'd2);
        pulse_clr();
        @(negedge clk);
        checkOutput("overrun_clr", 32'(overrun), 32'd0);

        cur.data    = 16'h0000;
        cur.delay   = 0;
        cur.respond = 1'b0;
        stim_q.push_back(cur);
        addr_q.push_back(ADDR_BASE + 7'(m_idx));
        pulse_eoc();
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_den", 32'(den), 32'd0);
        checkOutput("midrst_daddr", 32'(daddr), 32'h10);
        @(posedge clk); #1 rst = 1'b0;
        m_idx = 0;
        drdy  = 1'b1;
        do_in = 16'h5550;
        @(posedge clk); #1 drdy = 1'b0; do_in = 16'h0000;
        repeat (3) begin
            @(negedge clk);
            checkOutput("late_drdy_valid", 32'(valid), 32'd0);
            checkOutput("late_drdy_busy", 32'(busy), 32'd0);
        end
        applyStimulus(16'hABC0, 3, 1'b1);
        wait_idle();
`endif

        ready_rand = 1'b1;
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 5)) @(posedge clk);
            if ($urandom_range(0, 7) == 0)
                applyStimulus(16'($urandom), 0, 1'b0);
            else
                applyStimulus(16'($urandom), int'($urandom_range(1, 40)), 1'b1);
            wait_idle();
        end
        ready_rand = 1'b0;
        ready      = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        checkOutput("addr_drained", 32'(addr_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
